// File: rtl/i2c_req_arbiter.sv
// Purpose : round-robin share of one single-byte I2C master engine among NUM_REQ requesters, with a watchdog.
// Latency : accept at T, eng_start at T+1, rsp_valid one cycle after eng_done (or after watchdog expiry).
// Backpress: one transaction in flight; requests wait (valid held) while busy or while eng_busy is high.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/rw/addr/wdata    per-requester command (addr packed 7b, wdata packed 8b per requester)
//   req_ready                  one-hot accept pulse, combinational in the accept cycle
//   rsp_valid                  one-hot completion pulse to the granted requester
//   rsp_rdata/nack/timeout     shared result, held until the next completion
//   grant_id, busy             current owner of the engine, arbiter occupied
//   eng_start/rw/addr/wdata    launch pulse and registered command to the engine
//   eng_busy/done/rdata/nack   engine status and result
module i2c_req_arbiter #(
  parameter  int NUM_REQ     = 4,
  parameter  int TIMEOUT_CYC = 65535,
  localparam int GID_W       = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_nack,
  output logic                 rsp_timeout,
  output logic [GID_W-1:0]     grant_id,
  output logic                 busy,
  output logic                 eng_start,
  output logic                 eng_rw,
  output logic [6:0]           eng_addr,
  output logic [7:0]           eng_wdata,
  input  logic                 eng_busy,
  input  logic                 eng_done,
  input  logic [7:0]           eng_rdata,
  input  logic                 eng_nack
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t           state;
  logic [GID_W-1:0] last_grant;
  logic [WD_W-1:0]  wd_cnt;
  logic             run;        // low in the first cycle after reset so req_ready stays 0 during reset
  logic [GID_W-1:0] pick;
  logic             pick_vld;
  logic             grant_ok;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    int               cand;
    logic [GID_W-1:0] cidx;
    pick     = '0;
    pick_vld = 1'b0;
    cand     = 0;
    cidx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cidx = GID_W'(cand);
      if (!pick_vld && req_valid[cidx]) begin
        pick_vld = 1'b1;
        pick     = cidx;
      end
    end
  end

  assign grant_ok  = run && (state == S_IDLE) && pick_vld && !eng_busy;
  assign req_ready = grant_ok ? (NUM_REQ'(1) << pick) : '0;
  assign busy      = (state != S_IDLE) || grant_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      last_grant  <= GID_W'(NUM_REQ - 1);
      grant_id    <= '0;
      wd_cnt      <= '0;
      run         <= 1'b0;
      eng_start   <= 1'b0;
      eng_rw      <= 1'b0;
      eng_addr    <= '0;
      eng_wdata   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_nack    <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      run       <= 1'b1;
      eng_start <= 1'b0;
      rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (grant_ok) begin
            eng_rw    <= req_rw[pick];
            eng_addr  <= req_addr[7*int'(pick) +: 7];
            eng_wdata <= req_wdata[8*int'(pick) +: 8];
            grant_id  <= pick;
            eng_start <= 1'b1;
            state     <= S_START;
          end
        end
        S_START: begin
          wd_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
          // A done arriving on the expiry cycle still counts as a completion.
          if (eng_done) begin
            rsp_rdata   <= eng_rdata;
            rsp_nack    <= eng_nack;
            rsp_timeout <= 1'b0;
            rsp_valid   <= NUM_REQ'(1) << grant_id;
            state       <= S_RESP;
          end else if (wd_cnt == WD_LAST) begin
            rsp_rdata   <= 8'h00;
            rsp_nack    <= 1'b0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= NUM_REQ'(1) << grant_id;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          last_grant <= grant_id;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
